// File: rtl/divider_pkg.sv
// Shared types for the restoring divider: FSM state encoding and default operand width.
package divider_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract, keep or restore.
// Purely combinational; the result is consumed on the same clock edge by restoring_divider.
module div_step
    import divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH:0]   r,
    input  logic             q_msb,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH:0]   r_next,
    output logic             q_bit,
    output logic             sub_ok
);

    logic [WIDTH:0] s;
    logic [WIDTH:0] t;
    logic           r_top_unused;

    // The partial remainder is always below the divisor, so its top bit is zero
    // and only the low WIDTH bits take part in the shift.
    assign r_top_unused = r[WIDTH];

    assign s      = {r[WIDTH-1:0], q_msb};
    assign t      = s - {1'b0, d};
    assign sub_ok = ~t[WIDTH];
    assign q_bit  = sub_ok;
    assign r_next = sub_ok ? t : s;

endmodule

// File: rtl/restoring_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, result after WIDTH+1 cycles, ENTER ignored while busy.
// Define DIVIDER_DIV0_CHECK_EN to short-circuit a zero divisor straight to DONE with the div_zero flag set.
module restoring_divider
    import divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enter,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0]   r;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] d;

    logic [WIDTH:0]   r_next;
    logic             q_bit;
    logic             sub_ok;
    logic [WIDTH-1:0] q_next;

    div_step #(.WIDTH(WIDTH)) u_step (
        .r      (r),
        .q_msb  (q[WIDTH-1]),
        .d      (d),
        .r_next (r_next),
        .q_bit  (q_bit),
        .sub_ok (sub_ok)
    );

    assign q_next = {q[WIDTH-2:0], q_bit};

`ifdef DIVIDER_DIV0_CHECK_EN
    logic div_zero_q;
    assign div_zero = div_zero_q;
`else
    assign div_zero = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= HOLD;
            cnt       <= '0;
            r         <= '0;
            q         <= '0;
            d         <= '0;
            quotient  <= '0;
            remainder <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef DIVIDER_DIV0_CHECK_EN
            div_zero_q <= 1'b0;
`endif
        end else begin
            case (state)
                HOLD: begin
                    if (enter) begin
                        q   <= dividend;
                        d   <= divisor;
                        r   <= '0;
                        cnt <= '0;
`ifdef DIVIDER_DIV0_CHECK_EN
                        if (divisor == '0) begin
                            state      <= DONE;
                            done       <= 1'b1;
                            quotient   <= '1;
                            remainder  <= dividend;
                            div_zero_q <= 1'b1;
                        end else
`endif
                        begin
                            state <= ITER;
                            busy  <= 1'b1;
                        end
                    end
                end
                ITER: begin
                    r   <= r_next;
                    q   <= q_next;
                    cnt <= cnt + 1'b1;
                    // Results are published on the edge of the final step so they are
                    // already stable for the whole DONE cycle.
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        quotient  <= q_next;
                        remainder <= r_next[WIDTH-1:0];
`ifdef DIVIDER_DIV0_CHECK_EN
                        div_zero_q <= 1'b0;
`endif
                    end
                end
                DONE: begin
                    state <= HOLD;
                    done  <= 1'b0;
                end
                default: begin
                    state <= HOLD;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
